// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard for the ID stage: tracks variable-latency
// producers and stalls the ID instruction on RAW/WAW hazards.

module hazard_sb_entry #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic [LAT_W-1:0] set_lat,
  input  logic             wb_hit,
  output logic [LAT_W-1:0] cnt
);
  localparam logic [LAT_W-1:0] UNK = '1;

  // A new issue write wins over a wb_done clear, which wins over the countdown.
  always_ff @(posedge clk) begin
    if (rst)                           cnt <= '0;
    else if (set)                      cnt <= set_lat;
    else if (wb_hit && cnt == UNK)     cnt <= '0;
    else if (cnt != '0 && cnt != UNK)  cnt <= cnt - 1'b1;
  end
endmodule

module hazard_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int LAT_W    = 3,
  parameter int STALL_CW = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [ADDR_W-1:0]       id_rs1_add,
  input  logic                    id_rs1_used,
  input  logic [ADDR_W-1:0]       id_rs2_add,
  input  logic                    id_rs2_used,
  input  logic [ADDR_W-1:0]       id_rd_add,
  input  logic                    id_rd_we,
  input  logic [LAT_W-1:0]        id_lat,
  input  logic                    flush,
  input  logic                    wb_done,
  input  logic [ADDR_W-1:0]       wb_rd_add,
  output logic                    stall,
  output logic                    issue,
  output logic [(1<<ADDR_W)-1:0]  busy,
  output logic [STALL_CW-1:0]     stall_count
);
  localparam int NENT = 1 << ADDR_W;
  localparam logic [LAT_W-1:0] UNK = '1;

  logic [NENT-1:0][LAT_W-1:0] cnt;
  logic [LAT_W-1:0] rd_cnt;
  logic raw1, raw2, waw;

  assign rd_cnt = cnt[id_rd_add];
  assign raw1 = id_rs1_used && id_rs1_add != '0 && cnt[id_rs1_add] != '0;
  assign raw2 = id_rs2_used && id_rs2_add != '0 && cnt[id_rs2_add] != '0;
  // Younger write may only issue if it lands strictly after the pending one.
  assign waw  = id_rd_we && id_rd_add != '0 && rd_cnt != '0 &&
                (rd_cnt > id_lat || rd_cnt == UNK || id_lat == UNK);

  assign stall = !rst && id_valid && !flush && (raw1 || raw2 || waw);
  assign issue = !rst && id_valid && !flush && !stall;

  genvar r;
  generate
    for (r = 0; r < NENT; r++) begin : g_ent
      if (r == 0) begin : g_x0
        assign cnt[r] = '0;
      end else begin : g_trk
        hazard_sb_entry #(.LAT_W(LAT_W)) u_ent (
          .clk     (clk),
          .rst     (rst),
          .set     (issue && id_rd_we && id_rd_add == ADDR_W'(r) && id_lat != '0),
          .set_lat (id_lat),
          .wb_hit  (wb_done && wb_rd_add == ADDR_W'(r)),
          .cnt     (cnt[r])
        );
      end
      assign busy[r] = (cnt[r] != '0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)                              stall_count <= '0;
    else if (stall && stall_count != '1)  stall_count <= stall_count + 1'b1;
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: reference model feeds an expected-output
// queue each cycle, popped and compared mid-cycle, plus directed hazard scenarios.

module tb_hazard_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs1_used, id_rs2_used, id_rd_we, flush, wb_done;
  logic [4:0]  id_rs1_add, id_rs2_add, id_rd_add, wb_rd_add;
  logic [2:0]  id_lat;
  logic        stall, issue;
  logic [31:0] busy;
  logic [31:0] stall_count;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_add(id_rs1_add), .id_rs1_used(id_rs1_used),
    .id_rs2_add(id_rs2_add), .id_rs2_used(id_rs2_used),
    .id_rd_add(id_rd_add), .id_rd_we(id_rd_we), .id_lat(id_lat),
    .flush(flush), .wb_done(wb_done), .wb_rd_add(wb_rd_add),
    .stall(stall), .issue(issue), .busy(busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        issue;
    logic [31:0] busy;
    logic [31:0] scnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   mcnt[32];
  int   mscnt;
  logic obs_stall, obs_issue;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_stall();
    bit raw1, raw2, waw;
    int c;
    if (rst || !id_valid || flush) return 1'b0;
    raw1 = id_rs1_used && id_rs1_add != 0 && mcnt[id_rs1_add] != 0;
    raw2 = id_rs2_used && id_rs2_add != 0 && mcnt[id_rs2_add] != 0;
    c    = mcnt[id_rd_add];
    waw  = id_rd_we && id_rd_add != 0 && c != 0 && (c > int'(id_lat) || c == 7 || id_lat == 3'd7);
    return raw1 || raw2 || waw;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    for (int i = 0; i < 32; i++) b[i] = (mcnt[i] != 0);
    return b;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    mscnt = 0;
  endtask

  // One clock: predict, compare at negedge, advance the model at posedge.
  task automatic tick();
    exp_t e, p;
    bit   s, is;
    int   nx[32];
    s  = m_stall();
    is = !rst && id_valid && !flush && !s;
    e.stall = s; e.issue = is; e.busy = m_busy(); e.scnt = mscnt;
    exp_q.push_back(e);
    @(negedge clk);
    p = exp_q.pop_front();
    chk("stall", {63'd0, stall}, {63'd0, p.stall});
    chk("issue", {63'd0, issue}, {63'd0, p.issue});
    chk("busy",  {32'd0, busy}, {32'd0, p.busy});
    chk("stall_count", {32'd0, stall_count}, {32'd0, p.scnt});
    obs_stall = stall; obs_issue = issue;
    @(posedge clk);
    for (int r = 0; r < 32; r++) begin
      nx[r] = mcnt[r];
      if (mcnt[r] > 0 && mcnt[r] < 7) nx[r] = mcnt[r] - 1;
      if (wb_done && wb_rd_add == r && mcnt[r] == 7) nx[r] = 0;
      if (is && id_rd_we && id_rd_add == r && id_lat != 0) nx[r] = id_lat;
      if (r == 0 || rst) nx[r] = 0;
    end
    for (int r = 0; r < 32; r++) mcnt[r] = nx[r];
    if (rst) mscnt = 0;
    else if (s && mscnt != -1) mscnt++;
    #1;
  endtask

  task automatic idle();
    rst = 0; id_valid = 0; id_rs1_add = 0; id_rs1_used = 0; id_rs2_add = 0;
    id_rs2_used = 0; id_rd_add = 0; id_rd_we = 0; id_lat = 0; flush = 0;
    wb_done = 0; wb_rd_add = 0;
  endtask

  task automatic instr(input int rd, input bit we, input int lat,
                       input int rs1, input bit u1, input int rs2, input bit u2);
    id_valid = 1; id_rd_add = 5'(rd); id_rd_we = we; id_lat = 3'(lat);
    id_rs1_add = 5'(rs1); id_rs1_used = u1; id_rs2_add = 5'(rs2); id_rs2_used = u2;
  endtask

  initial begin
    int sc0, guard;
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    m_clear();
    tick();
    chk("rst_busy", {32'd0, busy}, 64'd0);
    chk("rst_stall", {63'd0, obs_stall}, 64'd0);
    idle();

    // load-use bubble
    instr(5, 1, 1, 1, 1, 2, 1); tick();
    chk("t1_ld_issue", {63'd0, obs_issue}, 64'd1);
    instr(6, 1, 0, 5, 1, 0, 0); tick();
    chk("t1_bubble", {63'd0, obs_stall}, 64'd1);
    tick();
    chk("t1_issue", {63'd0, obs_issue}, 64'd1);
    chk("t1_nostall", {63'd0, obs_stall}, 64'd0);

    // x0 never tracked
    instr(0, 1, 1, 0, 0, 0, 0); tick();
    instr(8, 1, 0, 0, 1, 0, 1); tick();
    chk("t2_stall", {63'd0, obs_stall}, 64'd0);
    chk("t2_busy", {32'd0, busy}, 64'd0);

    // unknown-latency divide, 10 stalled cycles then wb_done
    idle(); tick();
    instr(7, 1, 7, 1, 1, 2, 1); tick();
    sc0 = stall_count;
    instr(10, 1, 0, 7, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin wb_done = 1; wb_rd_add = 7; end
      tick();
      chk("t3_hold", {63'd0, obs_stall}, 64'd1);
    end
    wb_done = 0; tick();
    chk("t3_issue", {63'd0, obs_issue}, 64'd1);
    chk("t3_count", 64'(stall_count - sc0), 64'd10);

    // WAW against unknown producer, then against a shorter-latency one
    idle();
    instr(3, 1, 7, 0, 0, 0, 0); tick();
    instr(3, 1, 0, 0, 0, 0, 0); tick();
    chk("t4_waw_unk", {63'd0, obs_stall}, 64'd1);
    idle(); wb_done = 1; wb_rd_add = 3; tick();
    wb_done = 0;
    instr(4, 1, 3, 0, 0, 0, 0); tick();
    instr(4, 1, 1, 0, 0, 0, 0); tick();
    chk("t4_waw_lat", {63'd0, obs_stall}, 64'd1);
    guard = 0;
    while (!obs_issue && guard < 8) begin tick(); guard++; end
    chk("t4_waw_done", {63'd0, obs_issue}, 64'd1);

    // flush kills the stalled consumer but not the pending load
    idle();
    instr(5, 1, 2, 0, 0, 0, 0); tick();
    instr(11, 1, 0, 5, 1, 0, 0); flush = 1; tick();
    chk("t5_stall", {63'd0, obs_stall}, 64'd0);
    chk("t5_issue", {63'd0, obs_issue}, 64'd0);
    chk("t5_busy5", {63'd0, busy[5]}, 64'd1);
    idle(); tick(); tick();
    chk("t5_drain", {63'd0, busy[5]}, 64'd0);

    // reset drops an unknown-latency entry; late wb_done ignored
    instr(9, 1, 7, 0, 0, 0, 0); tick();
    idle(); rst = 1; tick();
    rst = 0; tick();
    chk("t6_busy", {32'd0, busy}, 64'd0);
    wb_done = 1; wb_rd_add = 9; tick();
    wb_done = 0; tick();
    chk("t6_late_wb", {32'd0, busy}, 64'd0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      instr($urandom_range(0, 15), $urandom_range(0, 1),
            ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 4),
            $urandom_range(0, 15), $urandom_range(0, 1),
            $urandom_range(0, 15), $urandom_range(0, 1));
      id_valid = ($urandom_range(0, 5) != 0);
      flush    = ($urandom_range(0, 9) == 0);
      wb_done  = ($urandom_range(0, 3) == 0);
      wb_rd_add = 5'($urandom_range(0, 15));
      rst      = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
